// File: rtl/spc_pkg.sv
// Shared definitions for the simple processor control unit: state encoding,
// opcode constants and instruction-word field positions.
package spc_pkg;

    // Instruction layout: [8:6] opcode, [5:3] X register, [2:0] Y register.
    localparam int IR_WIDTH = 9;
    localparam int OP_MSB   = 8;
    localparam int OP_LSB   = 6;
    localparam int X_MSB    = 5;
    localparam int X_LSB    = 3;
    localparam int Y_MSB    = 2;
    localparam int Y_LSB    = 0;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

endpackage

// File: rtl/decoder3to8.sv
// 3-to-8 one-hot decoder used to turn register fields into enable vectors.
module decoder3to8 (
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    assign onehot = 8'b0000_0001 << sel;

endmodule

// File: rtl/proc_ctrl.sv
// Multi-cycle control unit for a small bus-based processor. Fetches an
// instruction into IR on run, then sequences register/ALU enables over
// T1..T3. Optional feature macro: SPC_MVNZ_EN (conditional move on g_nz).
module proc_ctrl
    import spc_pkg::*;
#(
    parameter int IR_W = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [IR_W-1:0] din,
    input  logic            g_nz,
    output logic            ir_in,
    output logic [7:0]      r_in,
    output logic [7:0]      r_out,
    output logic            a_in,
    output logic            g_in,
    output logic            g_out,
    output logic            din_out,
    output logic            addsub,
    output logic            done,
    output logic            busy
);

    state_t          state_q;
    state_t          state_d;
    logic [IR_W-1:0] ir_q;
    logic [2:0]      opcode;
    logic [7:0]      x_oh;
    logic [7:0]      y_oh;
    logic            is_arith;

    assign opcode   = ir_q[OP_MSB:OP_LSB];
    assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign busy     = (state_q != T0);

    decoder3to8 u_dec_x (
        .sel    (ir_q[X_MSB:X_LSB]),
        .onehot (x_oh)
    );

    decoder3to8 u_dec_y (
        .sel    (ir_q[Y_MSB:Y_LSB]),
        .onehot (y_oh)
    );

`ifndef SPC_MVNZ_EN
    // g_nz only matters when conditional move is built in.
    logic unused_g_nz;
    assign unused_g_nz = g_nz;
`endif

    // State and instruction register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep every register updating from
        // pre-edge values, so ordering inside the block cannot matter.
        if (rst) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ir_in) begin
                ir_q <= din;
            end
        end
    end

    // Next-state and control-enable decode from state and IR.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case statements can leave a value held, which would infer a latch.
        state_d = state_q;
        ir_in   = 1'b0;
        r_in    = 8'h00;
        r_out   = 8'h00;
        a_in    = 1'b0;
        g_in    = 1'b0;
        g_out   = 1'b0;
        din_out = 1'b0;
        addsub  = 1'b0;
        done    = 1'b0;

        case (state_q)
            T0: begin
                // run is masked by rst so nothing is strobed while in reset.
                ir_in = run & ~rst;
                if (run) begin
                    state_d = T1;
                end
            end

            T1: begin
                case (opcode)
                    OP_MV: begin
                        r_out   = y_oh;
                        r_in    = x_oh;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        din_out = 1'b1;
                        r_in    = x_oh;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        r_out   = x_oh;
                        a_in    = 1'b1;
                        state_d = T2;
                    end
`ifdef SPC_MVNZ_EN
                    OP_MVNZ: begin
                        if (g_nz) begin
                            r_out = y_oh;
                            r_in  = x_oh;
                        end
                        done    = 1'b1;
                        state_d = T0;
                    end
`endif
                    default: begin
                        // Reserved opcode: complete as a NOP.
                        done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end

            T2: begin
                if (is_arith) begin
                    r_out   = y_oh;
                    g_in    = 1'b1;
                    addsub  = (opcode == OP_SUB);
                    state_d = T3;
                end else begin
                    state_d = T0;
                end
            end

            T3: begin
                if (is_arith) begin
                    g_out = 1'b1;
                    r_in  = x_oh;
                    done  = 1'b1;
                end
                state_d = T0;
            end

            default: begin
                state_d = T0;
            end
        endcase
    end

endmodule
